axis_byte_packer: RTL
=====================

# axis_byte_packer

Compacts the sparse 32-bit read stream produced by the AXI read-DMA stage into a dense byte stream. The DMA stage marks unaligned head and tail bytes with partial `tkeep`. This block removes the holes so that every output beat except the last carries 4 valid bytes, and the last beat is low-lane aligned. It sits directly downstream of the read DMA, between the DMA and the packet/descriptor consumers.

## Interface
- `COUNT_BITS`, default 16: width of the per-packet byte counter. Used only with `PACKER_STATS_EN`.
- `aclk` in 1: clock.
- `aresetn` in 1: reset, asynchronous, active-low.
- `din_tdata` in 32: input bytes; lane *i* is `[8i+7:8i]`.
- `din_tkeep` in 4: valid-byte mask. Any pattern is legal, including non-contiguous and 0000.
- `din_tlast` in 1: last beat of packet.
- `din_tvalid` in 1: input valid.
- `din_tready` out 1: input ready.
- `dout_tdata` out 32: packed bytes.
- `dout_tkeep` out 4: 1111, or a low-aligned mask on the last beat.
- `dout_tlast` out 1: last beat of packet.
- `dout_tvalid` out 1: output valid.
- `dout_tready` in 1: output ready.
- `stat_bytes` out COUNT_BITS: byte total of the last completed packet. Present only with `PACKER_STATS_EN`.
- `stat_valid` out 1: one-cycle completion pulse. Present only with `PACKER_STATS_EN`.

## Operation
**State**
- `acc_data[55:0]`: byte accumulator; byte 0 is the oldest.
- `acc_cnt` (0..7).
- `flush` flag.

**Input beat**
- Kept bytes are compacted in ascending lane order.
- `in_n` = popcount(`din_tkeep`).
- Compacted bytes are appended at byte position `acc_cnt` (after any output shift in the same cycle).

**Output**
- `dout_tdata` = `acc_data[31:0]`.
- `dout_tvalid` = (`acc_cnt` ≥ 4) OR `flush`.
- `dout_tlast` = `flush` AND `acc_cnt` ≤ 4.
- `dout_tkeep` = 1111 when not last. When last, `acc_cnt` selects the mask: 0→0000, 1→0001, 2→0011, 3→0111, 4→1111.
- An output fire removes min(4, `acc_cnt`) bytes and shifts the accumulator down.

**Input ready**
- `din_tready` = !`flush` AND (`acc_cnt` ≤ 3 OR (`acc_cnt` ≥ 4 AND `dout_tready`)).
- `din_tready` depends combinationally on `dout_tready`; this is legal AXIS.
- This guarantees `acc_cnt` never exceeds 7.

**Update rule**
- `acc_cnt_next` = `acc_cnt` − out_n + in_n, where out_n and in_n count only fired transfers.

**Packet end**
- An accepted beat with `din_tlast` sets `flush`.
- While `flush` is set, input is blocked.
- The output drains, non-last beats first, then the tlast beat.
- The tlast fire clears `flush` and sets `acc_cnt` = 0.

**Boundary rules**
- Zero-byte packet (tlast beat with `acc_cnt` 0 after append): emit exactly one beat with `tkeep` = 0000 and `tlast` = 1, so the packet delimiter is preserved.
- A `tkeep` = 0000 beat without tlast is accepted and has no effect.
- Reset mid-packet discards the accumulator. There is no partial output after reset.

## Timing
**Reset values**
- `dout_tvalid` 0, `dout_tlast` 0, `dout_tkeep` 0000, `dout_tdata` 0.
- `stat_valid` 0, `stat_bytes` 0.
- `acc_cnt` 0, `flush` 0.
- `din_tready` = 1 one cycle after reset deassertion.

**Latency**
- Input fire to first output valid: 1 cycle when the accumulated count reaches ≥ 4, or when tlast is taken.

**Throughput**
- With `dout_tready` held high, 1 beat/cycle sustained, aligned or unaligned.

**Handshake**
- `dout_tdata`, `dout_tkeep`, `dout_tlast` are register-driven.
- They stay stable while `dout_tvalid` is high and `dout_tready` is low.

## Configuration
**`PACKER_STATS_EN` defined**
- A counter sums `in_n` per packet and saturates at 2^COUNT_BITS−1.
- On the cycle after the output tlast fire:
  - `stat_valid` pulses high for 1 cycle;
  - `stat_bytes` takes the packet total and holds it until the next pulse;
  - the counter clears.

**`PACKER_STATS_EN` undefined**
- The counter and both stat ports are absent.
- Datapath behaviour is identical.

## Structure
**Shared package `e1000_axis_pkg`**
- `AXIS_LANES` = 4.
- Function for the last-beat keep mask from a count.
- Function for the 4-lane popcount.

**Sub-module `byte_compact4`**
- Combinational.
- Inputs: data[31:0], keep[3:0].
- Outputs: packed data[31:0], count[2:0].
- Instantiated once on the input path.

## Test plan
1. **Aligned packet:** 3 beats, tkeep 1111, tlast on beat 3, `dout_tready`=1 → 3 output beats, all keep 1111, tlast on the 3rd, no bubbles after the first.
2. **Unaligned head:** beats with keep 1110, 1111, 0001 (data bytes 01..08) → out 01020304 / 05060708 order preserved, keep 1111 with tlast on the single final beat; 2 beats total.
3. **Short packet:** single beat with keep 0100, tlast → one beat, byte in lane 0, keep 0001, tlast=1. With stats: `stat_bytes`=1, `stat_valid` pulses once.
4. **Zero-byte packet:** keep 0000, tlast → one beat, keep 0000, tlast=1. `stat_bytes`=0.
5. **Backpressure:** `dout_tready` random 50%, 64-byte packet starting at byte offset 3 → output data and keep stable while stalled, 16 full beats, byte sequence intact, `acc_cnt` never exceeds 7.
6. **Reset mid-packet:** assert `aresetn` low after 2 of 4 beats → outputs return to reset values. The next packet (2 beats, keep 1111) emits exactly 2 beats with no stale bytes.

Source files
------------

// File: rtl/e1000_axis_pkg.sv
// Shared AXI-Stream helpers for the e1000 DMA datapath: lane count, popcount
// and the low-aligned keep mask used on terminal beats.
package e1000_axis_pkg;

    localparam int AXIS_LANES = 4;

    function automatic logic [2:0] popcount4(input logic [3:0] keep);
        popcount4 = 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
    endfunction

    function automatic logic [3:0] last_keep(input logic [2:0] cnt);
        case (cnt)
            3'd0:    last_keep = 4'b0000;
            3'd1:    last_keep = 4'b0001;
            3'd2:    last_keep = 4'b0011;
            3'd3:    last_keep = 4'b0111;
            default: last_keep = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/byte_compact4.sv
// Moves the kept bytes of one 4-lane beat down to the low lanes in ascending
// lane order; unused upper lanes are driven to zero.
module byte_compact4
    import e1000_axis_pkg::*;
(
    input  logic [31:0] data,
    input  logic [3:0]  keep,
    output logic [31:0] pdata,
    output logic [2:0]  count
);

    logic [1:0] idx;

    always_comb begin
        pdata = '0;
        idx   = '0;
        for (int i = 0; i < AXIS_LANES; i++) begin
            if (keep[i]) begin
                pdata[{idx, 3'b000} +: 8] = data[i*8 +: 8];
                idx = idx + 2'd1;
            end
        end
        count = popcount4(keep);
    end

endmodule

// File: rtl/axis_byte_packer.sv
// Removes tkeep holes from the read-DMA stream so every beat but the last is
// full and the last is low-lane aligned. Define PACKER_STATS_EN for per-packet
// byte totals on stat_bytes/stat_valid.
module axis_byte_packer
    import e1000_axis_pkg::*;
#(
    parameter int COUNT_BITS = 16
)
(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [31:0]           din_tdata,
    input  logic [3:0]            din_tkeep,
    input  logic                  din_tlast,
    input  logic                  din_tvalid,
    output logic                  din_tready,
    output logic [31:0]           dout_tdata,
    output logic [3:0]            dout_tkeep,
    output logic                  dout_tlast,
    output logic                  dout_tvalid,
    input  logic                  dout_tready
`ifdef PACKER_STATS_EN
   ,output logic [COUNT_BITS-1:0] stat_bytes,
    output logic                  stat_valid
`endif
);

    logic [55:0] acc_data;
    logic [2:0]  acc_cnt;
    logic        flush;
    logic        rdy_en;

    logic [31:0] cmp_data;
    logic [2:0]  cmp_cnt;

    logic        in_fire, out_fire, last_fire;
    logic [2:0]  out_n, in_n, cnt_s;
    logic [55:0] shifted, appended;
    logic [55:0] acc_data_nx;
    logic [2:0]  acc_cnt_nx;

    byte_compact4 u_compact (
        .data  (din_tdata),
        .keep  (din_tkeep),
        .pdata (cmp_data),
        .count (cmp_cnt)
    );

    // Output view and handshake, all decoded from accumulator state
    always_comb begin
        dout_tvalid = (acc_cnt >= 3'd4) || flush;
        dout_tlast  = flush && (acc_cnt <= 3'd4);
        dout_tkeep  = dout_tlast ? last_keep(acc_cnt) : (dout_tvalid ? 4'b1111 : 4'b0000);
        dout_tdata  = acc_data[31:0];
        din_tready  = rdy_en && !flush && ((acc_cnt <= 3'd3) || dout_tready);

        out_fire  = dout_tvalid && dout_tready;
        in_fire   = din_tvalid && din_tready;
        last_fire = out_fire && dout_tlast;

        out_n = '0;
        if (out_fire)
            out_n = (acc_cnt >= 3'd4) ? 3'd4 : acc_cnt;
        in_n  = in_fire ? cmp_cnt : 3'd0;
        cnt_s = acc_cnt - out_n;

        // Bytes above acc_cnt are kept zero, so OR-ing in the new bytes is safe
        shifted     = acc_data >> {out_n, 3'b000};
        appended    = {24'b0, (in_fire ? cmp_data : 32'b0)} << {cnt_s, 3'b000};
        acc_data_nx = shifted | appended;
        acc_cnt_nx  = cnt_s + in_n;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_data <= '0;
            acc_cnt  <= '0;
            flush    <= 1'b0;
            rdy_en   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (last_fire) begin
                acc_data <= '0;
                acc_cnt  <= '0;
                flush    <= 1'b0;
            end else begin
                acc_data <= acc_data_nx;
                acc_cnt  <= acc_cnt_nx;
                if (in_fire && din_tlast)
                    flush <= 1'b1;
            end
        end
    end

`ifdef PACKER_STATS_EN
    logic [COUNT_BITS-1:0] byte_sum;

    function automatic logic [COUNT_BITS-1:0] sat_add(input logic [COUNT_BITS-1:0] a,
                                                      input logic [2:0] b);
        logic [COUNT_BITS:0] s;
        s = {1'b0, a} + (COUNT_BITS+1)'(b);
        sat_add = s[COUNT_BITS] ? {COUNT_BITS{1'b1}} : s[COUNT_BITS-1:0];
    endfunction

    // Input and terminal output never fire together, so clear and add cannot collide
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            byte_sum   <= '0;
            stat_bytes <= '0;
            stat_valid <= 1'b0;
        end else begin
            stat_valid <= last_fire;
            if (last_fire) begin
                stat_bytes <= byte_sum;
                byte_sum   <= '0;
            end else if (in_fire) begin
                byte_sum <= sat_add(byte_sum, cmp_cnt);
            end
        end
    end
`endif

endmodule
